// File: rtl/instr_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package instr_fetch_pkg;

  localparam int XLEN       = 32;
  localparam int INST_WIDTH = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch sequencing states; ERR is terminal until reset.
  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    FETCH_HOLD = 3'd2,
    FETCH_EXEC = 3'd3,
    FETCH_ERR  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage of the multicycle RV32I core: owns the PC, issues one
// instruction-memory read per instruction, hands the word to decode and
// waits for the sequencer's resolved next PC before fetching again.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [XLEN-1:0]       imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [XLEN-1:0]       inst_pc,
  output logic [XLEN-1:0]       pc_plus4,
  input  logic [XLEN-1:0]       next_pc,
  input  logic                  next_pc_valid,
  output logic                  fetch_fault
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;

  // The request address is always the architectural PC, and the not-taken
  // target is derived from it combinationally (wraps modulo 2^32).
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // Single sequencing FSM; all handshake outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= FETCH_REQ;
      pc             <= RESET_PC;
      inst           <= '0;
      inst_pc        <= '0;
      inst_valid     <= 1'b0;
      imem_req_valid <= 1'b0;
      fetch_fault    <= 1'b0;
    end else begin
      case (state)
        FETCH_REQ: begin
          // The request is raised one cycle after entering REQ from reset,
          // or together with the EXEC->REQ transition, and held until taken.
          if (imem_req_valid && imem_req_ready) begin
            imem_req_valid <= 1'b0;
            state          <= FETCH_WAIT;
          end else begin
            imem_req_valid <= 1'b1;
          end
        end
        FETCH_WAIT: begin
          if (imem_rsp_valid) begin
            inst       <= imem_rsp_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            state      <= FETCH_HOLD;
          end
        end
        FETCH_HOLD: begin
          // next_pc_valid is deliberately not looked at here; the sequencer's
          // target is only sampled once decode has taken the instruction.
          if (inst_valid && inst_ready) begin
            inst_valid <= 1'b0;
            state      <= FETCH_EXEC;
          end
        end
        FETCH_EXEC: begin
          if (next_pc_valid) begin
            if (next_pc[1:0] == 2'b00) begin
              pc             <= next_pc;
              imem_req_valid <= 1'b1;
              state          <= FETCH_REQ;
            end else begin
              fetch_fault <= 1'b1;
              state       <= FETCH_ERR;
            end
          end
        end
        FETCH_ERR: begin
          imem_req_valid <= 1'b0;
          inst_valid     <= 1'b0;
          fetch_fault    <= 1'b1;
        end
        default: begin
          imem_req_valid <= 1'b0;
          inst_valid     <= 1'b0;
          fetch_fault    <= 1'b1;
          state          <= FETCH_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with RESET_PC = 32'h100.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        next_pc_valid;
  logic        fetch_fault;

  int compared   = 0;
  int mismatched = 0;

  instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .pc_plus4       (pc_plus4),
    .next_pc        (next_pc),
    .next_pc_valid  (next_pc_valid),
    .fetch_fault    (fetch_fault)
  );

  // 10 ns core clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req_ready, input logic rsp_valid,
                               input logic [31:0] rsp_data, input logic i_ready,
                               input logic [31:0] npc, input logic npc_valid);
    imem_req_ready = req_ready;
    imem_rsp_valid = rsp_valid;
    imem_rsp_data  = rsp_data;
    inst_ready     = i_ready;
    next_pc        = npc;
    next_pc_valid  = npc_valid;
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // From REQ with the request visible: complete one fetch of word d and
  // stop in EXEC with no target offered yet.
  task automatic fetch_to_exec(input logic [31:0] d, input logic [31:0] exp_pc);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick(1);
    checkOutput("f2e_wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    applyStimulus(1'b0, 1'b1, d, 1'b0, 32'h0, 1'b0);
    tick(1);
    checkOutput("f2e_hold_inst", inst, d);
    checkOutput("f2e_hold_inst_pc", inst_pc, exp_pc);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    tick(1);
    checkOutput("f2e_exec_inst_valid", {31'b0, inst_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Reset values while rst_n is held low.
    #12;
    checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("rst_inst", inst, 32'h0);
    checkOutput("rst_inst_pc", inst_pc, 32'h0);
    checkOutput("rst_fault", {31'b0, fetch_fault}, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h100);
    checkOutput("rst_pc_plus4", pc_plus4, 32'h104);

    // Release between edges; request appears after the first rising edge.
    rst_n = 1'b1;
    tick(1);
    checkOutput("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("first_addr", imem_addr, 32'h100);

    // Minimum-latency instruction: REQ, WAIT, HOLD, EXEC, then REQ again.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick(1);
    checkOutput("t1_wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0);
    tick(1);
    checkOutput("t1_hold_inst_valid", {31'b0, inst_valid}, 32'd1);
    checkOutput("t1_hold_inst", inst, 32'h0000_0013);
    checkOutput("t1_hold_inst_pc", inst_pc, 32'h100);
    checkOutput("t1_hold_pc_plus4", pc_plus4, 32'h104);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    tick(1);
    checkOutput("t1_exec_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("t1_exec_req_valid", {31'b0, imem_req_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h104, 1'b1);
    tick(1);
    checkOutput("t1_req4_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("t1_req4_addr", imem_addr, 32'h104);
    checkOutput("t1_req4_pc_plus4", pc_plus4, 32'h108);

    // Memory stalls for 5 cycles with a spurious response during REQ.
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("t2_stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
      checkOutput("t2_stall_addr", imem_addr, 32'h104);
      checkOutput("t2_stall_inst", inst, 32'h0000_0013);
    end
    checkOutput("t2_stall_inst_valid", {31'b0, inst_valid}, 32'd0);

    // Fetch at 0x104, then stall decode for 3 cycles in HOLD.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b1, 32'h00A0_0093, 1'b0, 32'h0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h200, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("t3_hold_inst_valid", {31'b0, inst_valid}, 32'd1);
      checkOutput("t3_hold_inst", inst, 32'h00A0_0093);
      checkOutput("t3_hold_inst_pc", inst_pc, 32'h104);
      checkOutput("t3_hold_addr", imem_addr, 32'h104);
    end

    // Handshake and a taken target in the same cycle: only the handshake.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
    tick(1);
    checkOutput("t4_exec_addr", imem_addr, 32'h104);
    checkOutput("t4_exec_req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("t4_exec_inst_valid", {31'b0, inst_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h80, 1'b1);
    tick(1);
    checkOutput("t4_taken_req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("t4_taken_addr", imem_addr, 32'h80);
    checkOutput("t4_taken_pc_plus4", pc_plus4, 32'h84);

    // Jump to the top of the address space; pc_plus4 wraps to zero.
    fetch_to_exec(32'h0000_006F, 32'h80);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b1);
    tick(1);
    checkOutput("t4_wrap_addr", imem_addr, 32'hFFFF_FFFC);
    checkOutput("t4_wrap_pc_plus4", pc_plus4, 32'h0);

    // Misaligned target: sticky fault, no further requests.
    fetch_to_exec(32'h0000_0067, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h102, 1'b1);
    tick(1);
    checkOutput("t5_fault", {31'b0, fetch_fault}, 32'd1);
    checkOutput("t5_err_req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("t5_err_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 32'h1111_1111, 1'b1, 32'h200, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("t5_err_hold_req_valid", {31'b0, imem_req_valid}, 32'd0);
      checkOutput("t5_err_hold_inst_valid", {31'b0, inst_valid}, 32'd0);
      checkOutput("t5_err_hold_fault", {31'b0, fetch_fault}, 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_fault", {31'b0, fetch_fault}, 32'd0);
    checkOutput("t5_rst_addr", imem_addr, 32'h100);
    #2;
    rst_n = 1'b1;
    tick(1);
    checkOutput("t5_restart_req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("t5_restart_addr", imem_addr, 32'h100);

    // Complete a fetch so inst is non-zero, then reset mid-WAIT.
    fetch_to_exec(32'h1234_5678, 32'h100);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h108, 1'b1);
    tick(1);
    checkOutput("t6_req_addr", imem_addr, 32'h108);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick(1);
    checkOutput("t6_wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_inst", inst, 32'h0);
    checkOutput("t6_async_inst_pc", inst_pc, 32'h0);
    checkOutput("t6_async_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("t6_async_addr", imem_addr, 32'h100);
    checkOutput("t6_async_req_valid", {31'b0, imem_req_valid}, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
    tick(2);
    checkOutput("t6_inrst_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("t6_inrst_inst", inst, 32'h0);
    #2;
    rst_n = 1'b1;
    tick(1);
    checkOutput("t6_rel_req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("t6_rel_inst_valid", {31'b0, inst_valid}, 32'd0);
    tick(1);
    checkOutput("t6_spur_inst_valid", {31'b0, inst_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b1, 32'h0040_0113, 1'b0, 32'h0, 1'b0);
    tick(1);
    checkOutput("t6_fresh_inst_valid", {31'b0, inst_valid}, 32'd1);
    checkOutput("t6_fresh_inst", inst, 32'h0040_0113);
    checkOutput("t6_fresh_inst_pc", inst_pc, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
PC-holding fetch stage directly upstream of the sequencer in the multicycle RV32I core. Owns the architectural PC and issues one instruction-memory read per instruction over a valid/ready request channel. Hands the fetched word and its PC to decode, supplies pc+4 to the sequencer as its not-taken target, and waits for the sequencer's resolved next_pc before fetching again.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  instruction read request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_addr  out  32  read address (= pc)
imem_rsp_valid  in  1  read data valid
imem_rsp_data  in  32  read data
inst_valid  out  1  fetched instruction available to decode
inst_ready  in  1  decode accepts instruction
inst  out  32  fetched instruction word
inst_pc  out  32  PC of inst
pc_plus4  out  32  pc+4, feeds sequencer not-taken input
next_pc  in  32  sequencer-resolved next PC
next_pc_valid  in  1  next_pc is final for the current instruction
fetch_fault  out  1  sticky misaligned-target flag

Behaviour:
- Reset (async assert, any state): pc=RESET_PC; state=REQ; inst=0; inst_pc=0; inst_valid=0; imem_req_valid=0; fetch_fault=0.
  - First request is raised in the first cycle after rst_n deasserts; imem_req_valid is registered.
  - Memory shares rst_n; no response straddles a reset.
- States: REQ, WAIT, HOLD, EXEC, ERR. Encoding is 3 bits.
- REQ:
  - imem_req_valid=1, imem_addr=pc.
  - Address and valid stay stable while ready=0.
  - On valid&ready -> WAIT; imem_req_valid drops the next cycle.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid: inst<=imem_rsp_data, inst_pc<=pc, inst_valid<=1 -> HOLD.
  - The earliest response is 1 cycle after acceptance; an unbounded wait is legal.
- HOLD:
  - inst_valid=1; inst and inst_pc are stable until accepted.
  - On inst_valid&inst_ready -> EXEC; inst_valid is 0 from the next cycle.
  - inst_ready while inst_valid=0 is ignored.
- EXEC:
  - Waits for next_pc_valid.
  - If next_pc[1:0]==0: pc<=next_pc -> REQ.
  - Otherwise: fetch_fault<=1, pc unchanged -> ERR.
- ERR: terminal. No requests, inst_valid=0, fetch_fault=1 until reset.
- Ignored inputs:
  - next_pc_valid outside EXEC is ignored.
  - imem_rsp_valid outside WAIT is ignored and the data is not captured.
- Simultaneous events:
  - HOLD handshake and next_pc_valid in the same cycle: only the handshake is taken; next_pc is sampled in EXEC.
  - EXEC with next_pc_valid=1: the REQ request appears the next cycle.
- Arithmetic:
  - pc_plus4 = pc+32'd4, combinational from the pc register; modulo 2^32, so 32'hFFFF_FFFC -> 32'h0.
  - next_pc is taken verbatim; no sign or width change.
- Minimum per-instruction latency (REQ -> REQ):
  - 1 cycle request (ready=1), 1 cycle response, 1 cycle HOLD (ready=1), 1 cycle EXEC with valid present = 4 cycles.
- The pc register changes only at reset and on the EXEC->REQ transition.

Decomposition:
- Shared define file gets: the state encodings FETCH_REQ/WAIT/HOLD/EXEC/ERR (3'd0..3'd4), the default RESET_PC, and the INST_WIDTH/XLEN=32 constants.
- No sub-module; a single FSM plus registers is the natural split.

Test Plan:
- Reset with RESET_PC=32'h100, always-ready memory returning 32'h00000013 -> imem_addr=32'h100; inst=32'h13, inst_pc=32'h100 in HOLD; pc_plus4=32'h104; next_pc=32'h104 -> next request at 32'h104 exactly 4 cycles after the first.
- imem_req_ready held 0 for 5 cycles -> imem_req_valid=1 and imem_addr unchanged throughout; a spurious imem_rsp_valid during REQ is not captured.
- inst_ready held 0 for 3 cycles in HOLD -> inst and inst_pc stable; next_pc_valid pulsed during HOLD is ignored, and the PC updates only from next_pc in EXEC.
- Taken branch: in EXEC drive next_pc=32'h80 -> next imem_addr=32'h80; pc=32'hFFFF_FFFC gives pc_plus4=32'h0.
- Misaligned target next_pc=32'h102 -> fetch_fault=1 the next cycle, no further imem_req_valid; rst_n low then high -> fault clears, fetch restarts at RESET_PC.
- Assert rst_n low mid-WAIT -> outputs return to their reset values immediately (asynchronously); no inst_valid until a fresh fetch completes.
